// File: rtl/seg_num_display.sv
// Switch-value display engine: synchronised/debounced mode keys, hex or decimal (sequential
// double-dabble) conversion with sign handling, leading-zero blanking and overflow indication.
module seg_num_display #(
  parameter int WIDTH           = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    sw,
  input  logic [1:0]          key_n,
  output logic [WIDTH-1:0]    ledr,
  output logic [7*DIGITS-1:0] hex,
  output logic                signed_mode,
  output logic                dec_mode,
  output logic                busy
);

  localparam int NB  = (WIDTH + 1) / 3 + 1;
  localparam int NR  = (NB > DIGITS) ? NB : DIGITS;
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int SCW = $clog2(WIDTH + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ABS  = 2'd1;
  localparam logic [1:0] CONV = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  logic [WIDTH-1:0]    sw_s1, sw_s2;
  logic [1:0]          key_s1, key_s2, key_stb, press;
  logic [DCW-1:0]      dcnt [2];
  logic [1:0]          state;
  logic                valid, snap_signed, snap_dec, neg;
  logic [WIDTH-1:0]    snap_sw;
  logic [WIDTH:0]      sh;
  logic [4*NR-1:0]     bcd, adj, sh_ext;
  logic [SCW-1:0]      step;
  logic [7*DIGITS-1:0] seg_r, seg_next;
  int unsigned         sig, limit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // A press is the stable level falling 1->0; it flips the mode one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1      <= '1;
      key_s2      <= '1;
      key_stb     <= '1;
      press       <= '0;
      signed_mode <= 1'b0;
      dec_mode    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      key_s1      <= key_n;
      key_s2      <= key_s1;
      press       <= '0;
      signed_mode <= signed_mode ^ press[0];
      dec_mode    <= dec_mode ^ press[1];
      for (int unsigned i = 0; i < 2; i++) begin
        if (key_s2[i] == key_stb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          key_stb[i] <= key_s2[i];
          dcnt[i]    <= '0;
          press[i]   <= ~key_s2[i];
        end else begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end
      end
    end
  end

  assign sh_ext = {{(4*NR-WIDTH-1){1'b0}}, sh};

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < NR; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_comb begin
    sig = 1;
    for (int unsigned i = 0; i < NR; i++)
      if (bcd[4*i +: 4] != 4'd0) sig = i + 1;
    limit    = neg ? DIGITS - 1 : DIGITS;
    seg_next = '0;
    if (sig > limit) begin
      seg_next[6:0] = glyph(4'hE);
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++)
        if (i < sig) seg_next[7*i +: 7] = glyph(bcd[4*i +: 4]);
      if (neg) seg_next[7*(DIGITS-1) +: 7] = 7'h40;
    end
  end

  // Magnitude is formed in WIDTH+1 bits from the sign-extended value so the most negative input does not wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= 1'b0;
      snap_sw     <= '0;
      snap_signed <= 1'b0;
      snap_dec    <= 1'b0;
      neg         <= 1'b0;
      sh          <= '0;
      bcd         <= '0;
      step        <= '0;
      seg_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!valid || ({sw_s2, signed_mode, dec_mode} != {snap_sw, snap_signed, snap_dec})) begin
            snap_sw     <= sw_s2;
            snap_signed <= signed_mode;
            snap_dec    <= dec_mode;
            state       <= ABS;
          end
        end
        ABS: begin
          neg   <= snap_signed & snap_sw[WIDTH-1];
          sh    <= (snap_signed & snap_sw[WIDTH-1]) ? -{snap_sw[WIDTH-1], snap_sw} : {1'b0, snap_sw};
          bcd   <= '0;
          step  <= '0;
          state <= CONV;
        end
        CONV: begin
          if (!snap_dec) begin
            bcd   <= sh_ext;
            state <= LOAD;
          end else begin
            bcd  <= {adj[4*NR-2:0], sh[WIDTH]};
            sh   <= {sh[WIDTH-1:0], 1'b0};
            step <= step + SCW'(1);
            if (step == SCW'(WIDTH)) state <= LOAD;
          end
        end
        default: begin
          seg_r <= seg_next;
          valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ledr = sw_s2;
  assign hex  = (SEG_ACTIVE_LOW != 0) ? ~seg_r : seg_r;

endmodule
